// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: Mealy enables/flushes from a 4-state FSM.
// Optional performance counters are built when STALL_CTRL_PERF_EN is defined.
module stall_flush_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        Need_Stall,
  input  logic        Branch_Taken,
  input  logic        Jump_ID,
  input  logic        Mem_Req,
  input  logic        Mem_Ready,
  output logic        PC_WE,
  output logic        IFid_WE,
  output logic        IDex_WE,
  output logic        EXmem_WE,
  output logic        IFid_Flush,
  output logic        IDex_Flush,
  output logic        EXmem_Flush,
  output logic        Bubble_MA,
  output logic [1:0]  Ctrl_State
`ifdef STALL_CTRL_PERF_EN
  ,
  output logic [31:0] Stall_Cycles,
  output logic [15:0] Flush_Count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LDSTALL  = 2'b01,
    ST_MEMWAIT  = 2'b10,
    ST_REDIRECT = 2'b11
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_mem_hold;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_next;
  end

  // Next-state and Mealy enable/flush decode
  always_comb begin
    w_next      = r_state;
    w_mem_hold  = 1'b0;
    PC_WE       = 1'b0;
    IFid_WE     = 1'b0;
    IDex_WE     = 1'b0;
    EXmem_WE    = 1'b0;
    IFid_Flush  = 1'b0;
    IDex_Flush  = 1'b0;
    EXmem_Flush = 1'b0;
    Bubble_MA   = 1'b0;

    if (rst) begin
      IFid_Flush  = 1'b1;
      IDex_Flush  = 1'b1;
      EXmem_Flush = 1'b1;
      w_next      = ST_RUN;
    end else begin
      // In MEMWAIT the access is already known pending; only Mem_Ready releases it
      if (r_state == ST_MEMWAIT) w_mem_hold = !Mem_Ready;
      else                       w_mem_hold = Mem_Req && !Mem_Ready;

      if (w_mem_hold) begin
        w_next = ST_MEMWAIT;
      end else if (Branch_Taken) begin
        PC_WE      = 1'b1;
        IFid_WE    = 1'b1;
        IDex_WE    = 1'b1;
        EXmem_WE   = 1'b1;
        IFid_Flush = 1'b1;
        IDex_Flush = 1'b1;
        w_next     = ST_REDIRECT;
      end else if (Need_Stall) begin
        EXmem_WE    = 1'b1;
        EXmem_Flush = 1'b1;
        w_next      = ST_LDSTALL;
      end else if (Jump_ID) begin
        PC_WE      = 1'b1;
        IFid_WE    = 1'b1;
        IDex_WE    = 1'b1;
        EXmem_WE   = 1'b1;
        IFid_Flush = 1'b1;
        w_next     = ST_RUN;
      end else begin
        PC_WE    = 1'b1;
        IFid_WE  = 1'b1;
        IDex_WE  = 1'b1;
        EXmem_WE = 1'b1;
        w_next   = ST_RUN;
      end

      // Fetch latency delivers one wrong-path instruction after a redirect
      if (r_state == ST_REDIRECT) IFid_Flush = 1'b1;
      Bubble_MA = (r_state == ST_LDSTALL);
    end
  end

  assign Ctrl_State = r_state;

`ifdef STALL_CTRL_PERF_EN
  localparam int unsigned STALL_W = 32;
  localparam int unsigned FLUSH_W = 16;

  logic [STALL_W-1:0] r_stall_cycles;
  logic [FLUSH_W-1:0] r_flush_count;
  logic               w_any_flush;

  assign w_any_flush = IFid_Flush || IDex_Flush || EXmem_Flush;

  // Stall counter wraps; flush counter saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!PC_WE) r_stall_cycles <= r_stall_cycles + STALL_W'(1);
      if (w_any_flush && (r_flush_count != {FLUSH_W{1'b1}}))
        r_flush_count <= r_flush_count + FLUSH_W'(1);
    end
  end

  assign Stall_Cycles = r_stall_cycles;
  assign Flush_Count  = r_flush_count;
`endif

endmodule
